// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide/remainder unit.
//   - funct3[1:0] operation encodings
//   - controller state encoding
//   - the two special result constants used for divide-by-zero and
//     signed overflow
package rv32m_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    // Bit 0 of funct3 clear means the signed variant (DIV/REM).
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 of funct3 set selects the remainder rather than the quotient.
    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_core_unsigned.sv
// Iterative restoring unsigned divider, one quotient bit per step.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load_i       capture dividend/divisor, clear remainder and counter
//   step_i       perform one shift/trial-subtract iteration
//   dividend_i   unsigned dividend (magnitude)
//   divisor_i    unsigned divisor (magnitude), must be non-zero
//   quo_o        quotient register (final after WIDTH steps)
//   rem_o        partial/final remainder register
//   last_o       high while the counter sits on the final iteration
module div_core_unsigned #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             last_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    // The remainder is always below the divisor, so the shifted value is
    // below twice the divisor and fits in WIDTH+1 bits.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = '0;
        end else if (step_i) begin
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit feeding the register-file write port.
// States:
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one restoring iteration per cycle in div_core_unsigned
//   DONE  | result presented for one cycle, write issued unless rd==x0
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, op           request and funct3[1:0] operation select
//   dividend, divisor   rs1 / rs2 values, sampled on the accepting edge
//   rd                  destination register
//   busy, done          stall indication and one-cycle completion pulse
//   rg_wrt_en/addr/data register-file write port
module div_unit
    import rv32m_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  dividend,
    input  logic [WIDTH-1:0]  divisor,
    input  logic [ADDR_W-1:0] rd,
    output logic              busy,
    output logic              done,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic [WIDTH-1:0]  rg_wrt_data
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] rd_q;
    logic              rem_sel_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic              special_q;
    logic [WIDTH-1:0]  special_res_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  data_q;

    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, overflow, special;
    logic [WIDTH-1:0] special_res;
    logic             accept;
    logic             core_load, core_step, core_last;
    logic [WIDTH-1:0] core_quo, core_rem;
    logic [WIDTH-1:0] quo_fix, rem_fix, result;

    assign signed_op = is_signed_op(op);
    assign a_neg     = signed_op & dividend[WIDTH-1];
    assign b_neg     = signed_op & divisor[WIDTH-1];
    assign a_mag     = a_neg ? (WIDTH'(0) - dividend) : dividend;
    assign b_mag     = b_neg ? (WIDTH'(0) - divisor)  : divisor;

    assign div_zero  = (divisor == '0);
    assign overflow  = signed_op && (dividend == INT_MIN) && (divisor == ALL_ONES);
    assign special   = div_zero || overflow;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem_op(op) ? dividend : ALL_ONES;
        end else if (!is_rem_op(op)) begin
            special_res = INT_MIN;
        end
    end

    assign accept    = (state_q == IDLE) && start;
    assign core_load = accept && !special;
    assign core_step = (state_q == RUN);

    div_core_unsigned #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .reset      (reset),
        .load_i     (core_load),
        .step_i     (core_step),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quo_o      (core_quo),
        .rem_o      (core_rem),
        .last_o     (core_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = special ? DONE : RUN;
            RUN:     if (core_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_q          <= '0;
            rem_sel_q     <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            addr_q        <= '0;
            data_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q          <= rd;
                rem_sel_q     <= is_rem_op(op);
                neg_quo_q     <= a_neg ^ b_neg;
                neg_rem_q     <= a_neg;
                special_q     <= special;
                special_res_q <= special_res;
            end
            // Hold the last presented write so the port stays quiet between results.
            if (state_q == DONE) begin
                addr_q <= rd_q;
                data_q <= result;
            end
        end
    end

    assign quo_fix = neg_quo_q ? (WIDTH'(0) - core_quo) : core_quo;
    assign rem_fix = neg_rem_q ? (WIDTH'(0) - core_rem) : core_rem;
    assign result  = special_q ? special_res_q : (rem_sel_q ? rem_fix : quo_fix);

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign rg_wrt_en   = done && (rd_q != '0);
    assign rg_wrt_addr = done ? rd_q   : addr_q;
    assign rg_wrt_data = done ? result : data_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        op = 2'b00;
    logic [WIDTH-1:0]  dividend = '0;
    logic [WIDTH-1:0]  divisor = '0;
    logic [ADDR_W-1:0] rd = '0;
    logic              busy, done, rg_wrt_en;
    logic [ADDR_W-1:0] rg_wrt_addr;
    logic [WIDTH-1:0]  rg_wrt_data;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .dividend    (dividend),
        .divisor     (divisor),
        .rd          (rd),
        .busy        (busy),
        .done        (done),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_addr (rg_wrt_addr),
        .rg_wrt_data (rg_wrt_data)
    );

    typedef struct {
        logic [WIDTH-1:0]  data;
        logic [ADDR_W-1:0] addr;
        logic              en;
        int                lat;
    } exp_t;

    typedef struct {
        logic [1:0]        o;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [ADDR_W-1:0] r;
    } vec_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference: RISC-V M-extension semantics from SystemVerilog arithmetic.
    function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            2'b01: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            2'b10: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called at a negedge: presents one request across the next rising edge
    // and queues its expectation. Returns at the negedge of cycle 1.
    task automatic drive_op(input vec_t v);
        exp_t e;
        op       = v.o;
        dividend = v.a;
        divisor  = v.b;
        rd       = v.r;
        start    = 1'b1;
        e.data = model(v.o, v.a, v.b);
        e.addr = v.r;
        e.en   = (v.r != 0);
        e.lat  = model_lat(v.o, v.a, v.b);
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        rd       = ADDR_W'($urandom);
    endtask

    // Waits (bounded) for done, counting cycles after the start edge and
    // noting any write enable seen before the done cycle.
    task automatic collect(input int lat0, output int lat, output logic en,
                           output logic [ADDR_W-1:0] addr,
                           output logic [WIDTH-1:0] data, output bit stray);
        lat   = lat0;
        stray = 1'b0;
        while (!done && lat < TIMEOUT) begin
            if (rg_wrt_en) stray = 1'b1;
            @(negedge clk);
            lat++;
        end
        en   = rg_wrt_en;
        addr = rg_wrt_addr;
        data = rg_wrt_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rg_wrt_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/en=%b expected 000", {busy, done, rg_wrt_en});
        end
        checks++;
        if (rg_wrt_addr !== '0 || rg_wrt_data !== '0) begin
            errors++;
            $display("FAIL reset_port: addr=%h data=%h expected 0/0", rg_wrt_addr, rg_wrt_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        vec_t vs[$];
        vec_t v;
        exp_t e;
        int lat;
        logic en;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0] data;
        bit stray;
        vs.push_back('{2'b01, 32'd100, 32'd7, 5'd5});
        vs.push_back('{2'b11, 32'd100, 32'd7, 5'd6});
        vs.push_back('{2'b00, -32'sd100, 32'd7, 5'd1});
        vs.push_back('{2'b10, -32'sd100, 32'd7, 5'd2});
        vs.push_back('{2'b00, 32'd100, -32'sd7, 5'd3});
        vs.push_back('{2'b10, 32'd100, -32'sd7, 5'd4});
        vs.push_back('{2'b00, 32'd123, 32'd0, 5'd8});
        vs.push_back('{2'b11, 32'd123, 32'd0, 5'd9});
        vs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10});
        vs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11});
        vs.push_back('{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12});
        vs.push_back('{2'b01, 32'd9, 32'd3, 5'd0});
        vs.push_back('{2'b10, -32'sd7, -32'sd2, 5'd13});
        vs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 5'd31});
        for (int i = 0; i < 6; i++) begin
            v.o = 2'($urandom_range(0, 3));
            v.a = $urandom;
            v.b = $urandom >> $urandom_range(0, 28);
            v.r = ADDR_W'($urandom_range(1, 31));
            vs.push_back(v);
        end
        foreach (vs[i]) begin
            drive_op(vs[i]);
            collect(1, lat, en, addr, data, stray);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL arith[%0d] latency: got %0d expected %0d", i, lat, e.lat);
            end
            checks++;
            if (data !== e.data) begin
                errors++;
                $display("FAIL arith[%0d] data: got %h expected %h", i, data, e.data);
            end
            checks++;
            if (en !== e.en || addr !== e.addr) begin
                errors++;
                $display("FAIL arith[%0d] en/addr: got %b/%0d expected %b/%0d", i, en, addr, e.en, e.addr);
            end
            checks++;
            if (stray) begin
                errors++;
                $display("FAIL arith[%0d] early_write: got 1 expected 0", i);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rg_wrt_en !== 1'b0 || rg_wrt_data !== e.data) begin
                errors++;
                $display("FAIL arith[%0d] hold: busy=%b en=%b data=%h expected 0/0/%h",
                         i, busy, rg_wrt_en, rg_wrt_data, e.data);
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int lat;
        logic en;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0] data;
        bit stray;
        drive_op('{2'b01, 32'd100, 32'd7, 5'd5});
        repeat (4) @(negedge clk);
        op = 2'b01; dividend = 32'd50; divisor = 32'd5; rd = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(6, lat, en, addr, data, stray);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || data !== e.data || addr !== e.addr || en !== e.en) begin
            errors++;
            $display("FAIL ignore_run: lat=%0d data=%h addr=%0d en=%b expected %0d/%h/%0d/%b",
                     lat, data, addr, en, e.lat, e.data, e.addr, e.en);
        end
        // start held through the DONE edge must be ignored there
        op = 2'b00; dividend = 32'd77; divisor = 32'd0; rd = 5'd10; start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done: busy=%b done=%b expected 0/0", busy, done);
        end
        drive_op('{2'b11, 32'd1000, 32'd7, 5'd11});
        collect(1, lat, en, addr, data, stray);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || data !== e.data || addr !== e.addr || en !== e.en) begin
            errors++;
            $display("FAIL accept_idle: lat=%0d data=%h addr=%0d en=%b expected %0d/%h/%0d/%b",
                     lat, data, addr, en, e.lat, e.data, e.addr, e.en);
        end
        stray = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL ignore_extra: got extra activity expected none");
        end
    endtask

    task automatic test_back_to_back();
        vec_t vs[$];
        exp_t e;
        int lat;
        logic en;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0] data;
        bit stray;
        vs.push_back('{2'b00, 32'd1000, 32'd33, 5'd14});
        vs.push_back('{2'b01, 32'd5, 32'd0, 5'd15});
        vs.push_back('{2'b10, -32'sd1000, 32'd33, 5'd16});
        foreach (vs[i]) begin
            drive_op(vs[i]);
            collect(1, lat, en, addr, data, stray);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || data !== e.data || addr !== e.addr || en !== e.en || stray) begin
                errors++;
                $display("FAIL b2b[%0d]: lat=%0d data=%h addr=%0d en=%b expected %0d/%h/%0d/%b",
                         i, lat, data, addr, en, e.lat, e.data, e.addr, e.en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        exp_t e;
        drive_op('{2'b01, 32'd1000, 32'd3, 5'd7});
        e = sb.pop_back();
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, rg_wrt_en} !== 3'b000) begin
            errors++;
            $display("FAIL abort_ctrl: busy/done/en=%b expected 000", {busy, done, rg_wrt_en});
        end
        checks++;
        if (rg_wrt_data !== '0 || rg_wrt_addr !== '0) begin
            errors++;
            $display("FAIL abort_port: data=%h addr=%h expected 0/0", rg_wrt_data, rg_wrt_addr);
        end
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || rg_wrt_en || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_write: got %0d active cycles expected 0 (dropped %h)", seen, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
